// File: rtl/rr_arb5_ctrl.sv
// rr_arb5_ctrl: five-requester round-robin arbiter with hold limit and registered idle flag
// Ports:
//   clk_i     clock, all state on rising edge
//   rst_ni    asynchronous active-low reset
//   req_i     level-sensitive requests, bit i = requester i
//   gnt_o     registered one-hot grant, zero when no owner
//   gnt_id_o  binary index of the owner, meaningful only while gnt_vld_o=1
//   gnt_vld_o high while a grant is held
//   idle_o    registered NOR of all requests
module rr_arb5_ctrl #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] req_i,
  output logic [4:0] gnt_o,
  output logic [2:0] gnt_id_o,
  output logic       gnt_vld_o,
  output logic       idle_o
);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;
  localparam logic [HOLD_W-1:0] LIM = HOLD_W'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);
  logic [0:0]        state_q, state_d;
  logic [2:0]        ptr_q, ptr_d, id_q, id_d;
  logic [4:0]        gnt_q, gnt_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              idle_q;
  logic [4:0]        cand;
  logic [3:0]        sum;
  logic [2:0]        idx, win_id;
  logic              win_vld, own_req, at_lim, take, drop;
  always_comb begin
    // the current owner is never a candidate; in IDLE gnt_q is zero so all requests compete
    cand    = req_i & ~gnt_q;
    own_req = |(req_i & gnt_q);
    at_lim  = (MAX_HOLD != 0) && (cnt_q == LIM);
    win_vld = 1'b0;
    win_id  = '0;
    sum     = '0;
    idx     = '0;
    // scan from the farthest offset down so the nearest requester after ptr wins
    for (int i = 4; i >= 0; i--) begin
      sum = {1'b0, ptr_q} + 4'(i);
      idx = sum >= 4'd5 ? 3'(sum - 4'd5) : sum[2:0];
      if (cand[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
    take    = state_q == S_IDLE ? win_vld : (!own_req || at_lim) && win_vld;
    drop    = state_q == S_GRANT && !own_req && !win_vld;
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    gnt_d   = gnt_q;
    cnt_d   = state_q == S_GRANT && !at_lim ? cnt_q + 1'b1 : '0;
    if (take) begin
      state_d = S_GRANT;
      id_d    = win_id;
      gnt_d   = 5'b00001 << win_id;
      cnt_d   = '0;
      ptr_d   = win_id == 3'd4 ? 3'd0 : win_id + 3'd1;
    end else if (drop) begin
      state_d = S_IDLE;
      gnt_d   = '0;
      cnt_d   = '0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      idle_q  <= ~|req_i;
    end
  end
  assign gnt_o     = gnt_q;
  assign gnt_id_o  = id_q;
  assign gnt_vld_o = state_q == S_GRANT;
  assign idle_o    = idle_q;
endmodule

// File: tb/tb_rr_arb5_ctrl.sv
// tb_rr_arb5_ctrl: checks two arbiters (unlimited hold and hold limit 4) against a behavioural model
module tb_rr_arb5_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [4:0] req_i = '0;
  logic [4:0] g0, g4;
  logic [2:0] id0, id4;
  logic       v0, v4, i0, i4;
  logic [19:0] obs;
  int errors = 0;
  int checks = 0;
  int   m_own[2] = '{-1, -1};
  int   m_ptr[2] = '{0, 0};
  int   m_cnt[2] = '{0, 0};
  logic m_idle = 1'b1;
  always #5 clk_i = ~clk_i;
  rr_arb5_ctrl #(.MAX_HOLD(0)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i),
    .gnt_o(g0), .gnt_id_o(id0), .gnt_vld_o(v0), .idle_o(i0)
  );
  rr_arb5_ctrl #(.MAX_HOLD(4)) dut4 (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i),
    .gnt_o(g4), .gnt_id_o(id4), .gnt_vld_o(v4), .idle_o(i4)
  );
  assign obs = {g0, v0, i0, v0 ? id0 : 3'd0, g4, v4, i4, v4 ? id4 : 3'd0};
  function automatic bit has(input logic [4:0] r, input int k);
    return ((r >> k) & 5'd1) != 5'd0;
  endfunction
  function automatic int find(input int j, input logic [4:0] r, input int excl);
    for (int o = 0; o < 5; o++) begin
      int k = (m_ptr[j] + o) % 5;
      if (has(r, k) && k != excl) return k;
    end
    return -1;
  endfunction
  function automatic void give(input int j, input int w);
    m_own[j] = w;
    m_cnt[j] = 0;
    m_ptr[j] = (w + 1) % 5;
  endfunction
  function automatic void model_step(input int j, input logic [4:0] r);
    int mh = j == 1 ? 4 : 0;
    int w;
    bit held;
    if (m_own[j] < 0) begin
      w = find(j, r, -1);
      if (w >= 0) give(j, w);
    end else begin
      held = has(r, m_own[j]);
      if (held && (mh == 0 || m_cnt[j] < mh - 1)) m_cnt[j]++;
      else begin
        w = find(j, r, m_own[j]);
        if (w >= 0) give(j, w);
        else if (held) m_cnt[j] = 0;
        else m_own[j] = -1;
      end
    end
  endfunction
  function automatic logic [19:0] exp_all();
    logic [9:0] e[2];
    for (int j = 0; j < 2; j++)
      e[j] = m_own[j] >= 0 ? {5'b00001 << m_own[j], 1'b1, m_idle, 3'(m_own[j])}
                           : {5'b00000, 1'b0, m_idle, 3'b000};
    return {e[0], e[1]};
  endfunction
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_own  = '{-1, -1};
      m_ptr  = '{0, 0};
      m_cnt  = '{0, 0};
      m_idle = 1'b1;
    end else begin
      model_step(0, req_i);
      model_step(1, req_i);
      m_idle = ~|req_i;
    end
  end
  task automatic test_reset();
    rst_ni = 1'b0;
    req_i  = '0;
    repeat (4) begin
      @(negedge clk_i);
      checks++;
      if ({g0, v0, i0, id0, g4, v4, i4, id4} !== {5'b0, 1'b0, 1'b1, 3'b0, 5'b0, 1'b0, 1'b1, 3'b0}) begin
        errors++;
        $display("FAIL reset: got %b %b %b %b / %b %b %b %b", g0, v0, i0, id0, g4, v4, i4, id4);
      end
    end
    rst_ni = 1'b1;
  endtask
  task automatic test_rotation();
    req_i = 5'b11111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk_i);
        checks++;
        if (g0 !== 5'b00001 << k || g4 !== 5'b00001 << k) begin
          errors++;
          $display("FAIL rotation owner=%0d cyc=%0d: got %b/%b exp %b", k, c, g0, g4, 5'b00001 << k);
        end
        checks++;
        if (obs !== exp_all()) begin
          errors++;
          $display("FAIL rotation_model: got %h exp %h", obs, exp_all());
        end
        if (c == 2) req_i[k] = 1'b0;
      end
    end
    @(negedge clk_i);
    checks++;
    if ({g0, v0, i0, g4, v4, i4} !== {5'b0, 1'b0, 1'b1, 5'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rotation_end: got %b %b %b / %b %b %b", g0, v0, i0, g4, v4, i4);
    end
  endtask
  task automatic test_wrap();
    req_i = 5'b10000;
    @(negedge clk_i);
    checks++;
    if (g0 !== 5'b10000 || g4 !== 5'b10000) begin
      errors++;
      $display("FAIL wrap_own4: got %b/%b exp 10000", g0, g4);
    end
    req_i = 5'b00011;
    @(negedge clk_i);
    checks++;
    if (g0 !== 5'b00001 || id0 !== 3'd0 || g4 !== 5'b00001 || id4 !== 3'd0) begin
      errors++;
      $display("FAIL wrap_to0: got %b id%0d / %b id%0d exp 00001 id0", g0, id0, g4, id4);
    end
    req_i = '0;
    @(negedge clk_i);
    checks++;
    if (obs !== exp_all()) begin
      errors++;
      $display("FAIL wrap_model: got %h exp %h", obs, exp_all());
    end
  endtask
  task automatic test_hold_limit();
    req_i = 5'b00100;
    @(negedge clk_i);
    req_i = 5'b01100;
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (g4 !== (c <= 4 ? 5'b00100 : 5'b01000) || g0 !== 5'b00100) begin
        errors++;
        $display("FAIL hold_limit cyc=%0d: got %b/%b", c, g0, g4);
      end
      checks++;
      if (obs !== exp_all()) begin
        errors++;
        $display("FAIL hold_limit_model: got %h exp %h", obs, exp_all());
      end
      if (c < 5) @(negedge clk_i);
    end
    req_i = '0;
    @(negedge clk_i);
    req_i = 5'b00100;
    repeat (10) begin
      @(negedge clk_i);
      checks++;
      if (g4 !== 5'b00100 || v4 !== 1'b1 || g0 !== 5'b00100) begin
        errors++;
        $display("FAIL hold_alone: got %b/%b exp 00100", g0, g4);
      end
      checks++;
      if (obs !== exp_all()) begin
        errors++;
        $display("FAIL hold_alone_model: got %h exp %h", obs, exp_all());
      end
    end
    req_i = '0;
    @(negedge clk_i);
  endtask
  task automatic test_async_reset();
    req_i = 5'b00010;
    repeat (2) @(negedge clk_i);
    checks++;
    if (g0 !== 5'b00010 || g4 !== 5'b00010) begin
      errors++;
      $display("FAIL areset_own1: got %b/%b exp 00010", g0, g4);
    end
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({g0, v0, g4, v4} !== 12'b0) begin
      errors++;
      $display("FAIL areset_drop: got %b %b / %b %b exp zero", g0, v0, g4, v4);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    req_i  = 5'b11111;
    @(negedge clk_i);
    checks++;
    if (g0 !== 5'b00001 || g4 !== 5'b00001 || obs !== exp_all()) begin
      errors++;
      $display("FAIL areset_restart: got %b/%b obs %h exp %h", g0, g4, obs, exp_all());
    end
    req_i = '0;
    @(negedge clk_i);
  endtask
  task automatic test_pulse();
    req_i = 5'b00100;
    @(negedge clk_i);
    req_i = '0;
    checks++;
    if (i0 !== 1'b0 || g0 !== 5'b00100 || g4 !== 5'b00100) begin
      errors++;
      $display("FAIL pulse_grant: idle=%b gnt=%b/%b exp idle=0 gnt=00100", i0, g0, g4);
    end
    @(negedge clk_i);
    checks++;
    if (i0 !== 1'b1 || g0 !== 5'b0 || v0 !== 1'b0 || i4 !== 1'b1 || g4 !== 5'b0) begin
      errors++;
      $display("FAIL pulse_idle: idle=%b gnt=%b vld=%b exp idle=1 gnt=0 vld=0", i0, g0, v0);
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) req_i = 5'($urandom) & 5'($urandom);
      else if ($urandom_range(0, 5) == 0) req_i = 5'($urandom);
      @(negedge clk_i);
      checks++;
      if (obs !== exp_all()) begin
        errors++;
        $display("FAIL random n=%0d req=%b: got %h exp %h", n, req_i, obs, exp_all());
      end
    end
    req_i = '0;
  endtask
  initial begin
    test_reset();
    test_rotation();
    test_wrap();
    test_hold_limit();
    test_async_reset();
    test_pulse();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
